// File: rtl/uc_bcast_sched.sv
// Unit-clause broadcast scheduler: loads memory unit clauses, then round-robins engine queue heads.
// Check in the accept cycle, broadcast registered 1 cycle later; any full engine stalls all acceptance.
`ifndef NUM_ENGINE
`define NUM_ENGINE 4
`endif
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 255
`endif

module uc_bcast_sched #(
  parameter  int NUM_ENGINE  = `NUM_ENGINE,
  parameter  int LIT_IDX_MAX = `LIT_IDX_MAX,
  localparam int W           = $clog2(LIT_IDX_MAX) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem2sch_valid,
  input  logic                  mem2sch_done,
  input  logic signed [W-1:0]   mem2sch,
  output logic                  mem2sch_ready,
  input  logic signed [W-1:0]   eng2sch_lit [NUM_ENGINE],
  input  logic [NUM_ENGINE-1:0] eng2sch_valid,
  input  logic [NUM_ENGINE-1:0] eng2sch_busy,
  output logic [NUM_ENGINE-1:0] sch2eng_pop,
  input  logic [NUM_ENGINE-1:0] eng2sch_full,
  output logic signed [W-1:0]   sch2eng_lit,
  output logic                  sch2eng_valid,
  output logic                  conflict,
  output logic                  done
);

  localparam int PW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int TN = LIT_IDX_MAX + 1;
  localparam int IW = $clog2(TN);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_CONFLICT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [TN-1:0]       assigned, value;  // entry 0 never written
  logic [PW-1:0]       rr_ptr, grant;
  logic                grant_vld, stall, accept, idle;
  logic                lit_ok, cand_pos, is_new, is_contra;
  logic signed [W-1:0] cand;
  logic [W-1:0]        mag;
  logic [IW-1:0]       idx;

  assign stall = |eng2sch_full;

  always_comb begin
    int e;
    grant_vld = 1'b0;
    grant     = '0;
    e         = 0;
    for (int k = 0; k < NUM_ENGINE; k++) begin
      e = (int'(rr_ptr) + k) % NUM_ENGINE;
      if (!grant_vld && eng2sch_valid[e]) begin
        grant_vld = 1'b1;
        grant     = PW'(e);
      end
    end
  end

  always_comb begin
    accept = 1'b0;
    cand   = mem2sch;
    if (!rst && !stall) begin
      if (state == S_LOAD) begin
        accept = mem2sch_valid;
      end else if (state == S_RUN) begin
        accept = grant_vld;
        cand   = eng2sch_lit[grant];
      end
    end
  end

  // Unsigned negation keeps the most negative literal's magnitude correct.
  assign mag       = cand[W-1] ? $unsigned(-cand) : $unsigned(cand);
  assign idx       = mag[IW-1:0];
  assign cand_pos  = !cand[W-1];
  assign lit_ok    = (cand != '0) && (mag <= W'(LIT_IDX_MAX));
  assign is_new    = lit_ok && !assigned[idx];
  assign is_contra = lit_ok && assigned[idx] && (value[idx] != cand_pos);

  always_ff @(posedge clk) begin
    if (rst) begin
      assigned <= '0;
      value    <= '0;
    end else if (accept && is_new) begin
      assigned[idx] <= 1'b1;
      value[idx]    <= cand_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      sch2eng_valid <= 1'b0;
      sch2eng_lit   <= '0;
    end else begin
      if (state == S_RUN && accept) begin
        rr_ptr <= (grant == PW'(NUM_ENGINE - 1)) ? '0 : grant + PW'(1);
      end
      sch2eng_valid <= accept && is_new;
      if (accept && is_new) begin
        sch2eng_lit <= cand;
      end
    end
  end

  assign idle = !(|eng2sch_valid) && !(|eng2sch_busy) && !sch2eng_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // A stalled memory literal keeps us in LOAD even if done is already high.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (accept && is_contra)                               state_nxt = S_CONFLICT;
        else if (mem2sch_done && !(mem2sch_valid && !accept))  state_nxt = S_RUN;
      end
      S_RUN: begin
        if (accept && is_contra) state_nxt = S_CONFLICT;
        else if (idle)           state_nxt = S_DONE;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    mem2sch_ready = 1'b0;
    conflict      = 1'b0;
    done          = 1'b0;
    sch2eng_pop   = '0;
    case (state)
      S_LOAD:     mem2sch_ready = !rst && !stall;
      S_RUN:      if (accept) sch2eng_pop[grant] = 1'b1;
      S_CONFLICT: conflict = 1'b1;
      S_DONE:     done = 1'b1;
      default:    mem2sch_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uc_bcast_sched.sv
// Directed bench for uc_bcast_sched: driver feeds memory/engine heads, monitor scores broadcasts.
module tb_uc_bcast_sched;

  localparam int NE   = 4;
  localparam int LMAX = 255;
  localparam int W    = $clog2(LMAX) + 1;

  typedef struct {
    logic signed [W-1:0] lit;
    int                  due;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                mem2sch_valid = 1'b0;
  logic                mem2sch_done = 1'b0;
  logic signed [W-1:0] mem2sch = '0;
  logic                mem2sch_ready;
  logic signed [W-1:0] eng2sch_lit [NE];
  logic [NE-1:0]       eng2sch_valid = '0;
  logic [NE-1:0]       eng2sch_busy = '0;
  logic [NE-1:0]       sch2eng_pop;
  logic [NE-1:0]       eng2sch_full = '0;
  logic signed [W-1:0] sch2eng_lit;
  logic                sch2eng_valid;
  logic                conflict;
  logic                done;

  uc_bcast_sched #(.NUM_ENGINE(NE), .LIT_IDX_MAX(LMAX)) dut (
    .clk(clk), .rst(rst),
    .mem2sch_valid(mem2sch_valid), .mem2sch_done(mem2sch_done), .mem2sch(mem2sch),
    .mem2sch_ready(mem2sch_ready),
    .eng2sch_lit(eng2sch_lit), .eng2sch_valid(eng2sch_valid), .eng2sch_busy(eng2sch_busy),
    .sch2eng_pop(sch2eng_pop), .eng2sch_full(eng2sch_full),
    .sch2eng_lit(sch2eng_lit), .sch2eng_valid(sch2eng_valid),
    .conflict(conflict), .done(done)
  );

  always #5 clk = ~clk;

  // Stimulus state
  logic                mem_v = 1'b0, mem_d = 1'b0;
  logic signed [W-1:0] mem_l = '0;
  logic [NE-1:0]       full = '0, busy = '0;
  logic signed [W-1:0] eq [NE][$];
  int                  exp_pop [$];

  // Reference assignment table and broadcast scoreboard
  bit [LMAX:0] ref_asg = '0, ref_val = '0;
  bit          ref_stop = 1'b0;
  exp_t        sb_q [$];
  exp_t        mon_e;

  // Values sampled each cycle between the edges
  logic [NE-1:0]       s_pop;
  logic                s_rdy, s_bv, s_conf, s_done;
  logic signed [W-1:0] s_bl;
  bit                  last_acc;

  int n_chk = 0, n_fail = 0, bc_cnt = 0, edge_n = 0;

  always @(posedge clk) edge_n++;

  always begin
    @(posedge clk);
    #1;
    if (sch2eng_valid) begin
      bc_cnt++;
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL bcast_unexpected: got lit %0d at edge %0d, expected no broadcast", sch2eng_lit, edge_n);
      end else begin
        mon_e = sb_q.pop_front();
        if (sch2eng_lit != mon_e.lit || edge_n != mon_e.due) begin
          n_fail++;
          $display("FAIL bcast: got lit %0d at edge %0d, expected lit %0d at edge %0d",
                   sch2eng_lit, edge_n, mon_e.lit, mon_e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input logic signed [W-1:0] l, input int due);
    int   m;
    bit   pos;
    exp_t e;
    m   = (int'(l) < 0) ? -int'(l) : int'(l);
    pos = (int'(l) > 0);
    if (ref_stop || m == 0 || m > LMAX) return;
    if (!ref_asg[m]) begin
      ref_asg[m] = 1'b1;
      ref_val[m] = pos;
      e.lit = l;
      e.due = due;
      sb_q.push_back(e);
    end else if (ref_val[m] != pos) begin
      ref_stop = 1'b1;
    end
  endtask

  task automatic cyc();
    bit mem_acc;
    int due;
    @(negedge clk);
    mem2sch_valid = mem_v;
    mem2sch_done  = mem_d;
    mem2sch       = mem_l;
    eng2sch_full  = full;
    eng2sch_busy  = busy;
    for (int i = 0; i < NE; i++) begin
      eng2sch_valid[i] = (eq[i].size() != 0);
      eng2sch_lit[i]   = (eq[i].size() != 0) ? eq[i][0] : '0;
    end
    #1;
    s_pop  = sch2eng_pop;
    s_rdy  = mem2sch_ready;
    s_bv   = sch2eng_valid;
    s_bl   = sch2eng_lit;
    s_conf = conflict;
    s_done = done;
    if (s_pop != '0) begin
      n_chk++;
      if (!$onehot(s_pop) || exp_pop.size() == 0 || s_pop != (NE'(1) << exp_pop[0])) begin
        n_fail++;
        $display("FAIL pop_order: got pop=%b expected engine %0d", s_pop,
                 (exp_pop.size() != 0) ? exp_pop[0] : -1);
      end
      if (exp_pop.size() != 0) void'(exp_pop.pop_front());
    end
    mem_acc = mem_v && s_rdy && !rst;
    due     = edge_n + 1;
    if (!rst) begin
      if (mem_acc) model(mem_l, due);
      for (int i = 0; i < NE; i++)
        if (s_pop[i] && eq[i].size() != 0) model(eq[i][0], due);
    end
    @(posedge clk);
    #2;
    if (rst) begin
      ref_asg  = '0;
      ref_val  = '0;
      ref_stop = 1'b0;
      sb_q.delete();
    end
    for (int i = 0; i < NE; i++)
      if (s_pop[i] && eq[i].size() != 0) void'(eq[i].pop_front());
    last_acc = mem_acc;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    mem_v = 1'b0;
    mem_d = 1'b0;
    full  = '0;
    busy  = '0;
    for (int i = 0; i < NE; i++) eq[i].delete();
    exp_pop.delete();
    cyc();
    cyc();
    chk("rst_bcast_valid", s_bv, 0);
    chk("rst_bcast_lit", s_bl, 0);
    chk("rst_conflict", s_conf, 0);
    chk("rst_done", s_done, 0);
    chk("rst_pop", s_pop, 0);
    chk("rst_mem_ready", s_rdy, 0);
    rst    = 1'b0;
    bc_cnt = 0;
  endtask

  task automatic mem_send(input logic signed [W-1:0] l);
    bit ok;
    ok    = 1'b0;
    mem_v = 1'b1;
    mem_l = l;
    for (int k = 0; k < 20 && !ok; k++) begin
      cyc();
      ok = last_acc;
    end
    mem_v = 1'b0;
    chk("mem_accept", ok, 1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!s_done && k < 20) begin
      cyc();
      k++;
    end
    chk(name, s_done, 1);
  endtask

  initial begin
    // Memory load: five new literals, then done moves to RUN and idles to DONE
    do_reset();
    mem_send(9'sd10); mem_send(9'sd20); mem_send(9'sd30); mem_send(9'sd40); mem_send(9'sd50);
    mem_d = 1'b1;
    cyc(); chk("t1_ready_done_cycle", s_rdy, 1);
    cyc(); chk("t1_ready_in_run", s_rdy, 0); chk("t1_done_early", s_done, 0);
    cyc(); chk("t1_done", s_done, 1);
    chk("t1_bcast_count", bc_cnt, 5);

    // Duplicate drop and round-robin wrap (pops 2,3 then 0 before 3)
    do_reset();
    mem_send(9'sd5);
    eq[2].push_back(9'sd5);
    eq[3].push_back(-9'sd7); eq[3].push_back(9'sd13);
    exp_pop = '{2, 3, 0, 3};
    mem_d = 1'b1;
    cyc(); chk("t2_no_pop_in_load", s_pop, 0);
    cyc(); cyc();
    eq[0].push_back(9'sd12);
    cyc(); cyc();
    wait_done("t2_done");
    chk("t2_pops_left", exp_pop.size(), 0);
    chk("t2_bcast_count", bc_cnt, 4);

    // Conflict: -3 from memory, 3 from engine 0
    do_reset();
    mem_send(-9'sd3);
    eq[0].push_back(9'sd3);
    exp_pop = '{0};
    mem_d = 1'b1;
    cyc();
    cyc(); chk("t3_pop_seen", s_pop, 1); chk("t3_conflict_same_cycle", s_conf, 0);
    cyc(); chk("t3_conflict", s_conf, 1); chk("t3_ready", s_rdy, 0);
    eq[1].push_back(9'sd20);
    cyc(); cyc(); cyc(); chk("t3_no_pop", s_pop, 0);
    eq[1].delete();
    cyc(); cyc(); cyc();
    chk("t3_done_blocked", s_done, 0);
    chk("t3_conflict_sticky", s_conf, 1);
    chk("t3_bcast_count", bc_cnt, 1);

    // Round-robin with a 2-cycle stall on engine 1's full
    do_reset();
    eq[0].push_back(9'sd31); eq[1].push_back(9'sd32);
    eq[2].push_back(9'sd33); eq[3].push_back(9'sd34);
    exp_pop = '{0, 1, 2, 3};
    mem_d = 1'b1;
    cyc();
    cyc();
    full = 4'b0010;
    cyc(); chk("t4_stall1_pop", s_pop, 0); chk("t4_stall1_bv", s_bv, 1);
    cyc(); chk("t4_stall2_pop", s_pop, 0); chk("t4_stall2_bv", s_bv, 0);
    full = '0;
    cyc(); chk("t4_resume_bv", s_bv, 0); chk("t4_resume_pop", s_pop, 2);
    cyc(); cyc();
    wait_done("t4_done");
    chk("t4_pops_left", exp_pop.size(), 0);
    chk("t4_bcast_count", bc_cnt, 4);

    // Completion timing: valid, then busy, then a stalled idle cycle, then true idle
    do_reset();
    mem_send(9'sd40);
    eq[0].push_back(9'sd41);
    exp_pop = '{0};
    mem_d = 1'b1;
    cyc();
    cyc();
    busy = 4'b0001;
    cyc(); cyc();
    busy = '0;
    full = 4'b0100;
    cyc(); chk("t5_done_stalled", s_done, 0);
    full = '0;
    cyc(); chk("t5_done_idle_cycle", s_done, 0);
    cyc(); chk("t5_done", s_done, 1); chk("t5_conflict", s_conf, 0);
    chk("t5_bcast_count", bc_cnt, 2);

    // Invalid heads dropped, then reset mid-run clears the table
    do_reset();
    mem_send(9'sd10);
    eq[1].push_back(9'sd0); eq[1].push_back(-9'sd256); eq[1].push_back(9'sd77);
    exp_pop = '{1, 1, 1};
    mem_d = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    busy = 4'b0010;
    cyc(); cyc(); chk("t6_still_running", s_done, 0);
    chk("t6_pops_left", exp_pop.size(), 0);
    chk("t6_bcast_count", bc_cnt, 2);
    eq[1].push_back(9'sd78);
    rst = 1'b1;
    cyc(); chk("t6_rst_no_pop", s_pop, 0);
    do_reset();
    mem_send(9'sd10);
    cyc();
    chk("t6_rebcast_count", bc_cnt, 1);

    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uc_bcast_sched.md
# uc_bcast_sched

Unit-clause broadcast scheduler for the BCP engine array. It accepts the initial unit clauses from memory and then round-robins over the per-engine implied-literal queue heads. Every literal it accepts is checked against an internal variable assignment table: duplicates are dropped, contradictions raise a sticky conflict, and new assignments are broadcast to all engines. It sits between the clause memory loader and the `NUM_ENGINE` engines, in the position the unit-clause arbiter wrapper occupies.

## Interface
- `NUM_ENGINE`, default `` `NUM_ENGINE `` (4): number of engines.
- `LIT_IDX_MAX`, default `` `LIT_IDX_MAX `` (255): largest variable index.
- Derived: `W = $clog2(LIT_IDX_MAX)+1`, the width of a signed literal.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem2sch_valid`  in  1  memory unit-clause literal valid.
- `mem2sch_done`  in  1  memory has no more unit clauses (level).
- `mem2sch`  in  signed W  memory literal.
- `mem2sch_ready`  out  1  memory literal accepted this cycle.
- `eng2sch_lit`  in  signed [NUM_ENGINE][W]  head literal of each engine queue.
- `eng2sch_valid`  in  NUM_ENGINE  head is valid.
- `eng2sch_busy`  in  NUM_ENGINE  engine still propagating.
- `sch2eng_pop`  out  NUM_ENGINE  one-hot pop of the granted engine head (combinational).
- `eng2sch_full`  in  NUM_ENGINE  engine input queue full.
- `sch2eng_lit`  out  signed W  broadcast literal (registered).
- `sch2eng_valid`  out  1  broadcast valid (registered).
- `conflict`  out  1  sticky conflict flag.
- `done`  out  1  sticky propagation-complete flag.

## Operation
- Literal encoding:
  - variable = |lit|; value = (lit > 0).
  - lit == 0 or |lit| > LIT_IDX_MAX is invalid: it is consumed and dropped, with no table change.
- Assignment table: `assigned[1..LIT_IDX_MAX]` and `value[1..LIT_IDX_MAX]`, held in flops and cleared by `rst`.
- `stall` = OR of `eng2sch_full`. While stalled, nothing is accepted, no pop occurs and no broadcast is issued.
- Check of a candidate literal L, done in the same cycle it is accepted:
  - **NEW** (variable unassigned): set assigned and value; next cycle `sch2eng_valid`=1 and `sch2eng_lit`=L.
  - **DUP** (assigned, same value): drop silently.
  - **CONTRA** (assigned, opposite value): go to CONFLICT; no broadcast.
- States (reset lands in LOAD):
  - **LOAD**:
    - `mem2sch_ready` = !stall.
    - Accept `mem2sch` when valid && ready and check it.
    - `mem2sch_done` moves to RUN. If valid and done arrive in the same cycle and the literal is accepted, it is processed first.
    - Engine heads are never popped in LOAD.
  - **RUN**:
    - Round-robin grant among `eng2sch_valid`, starting at `rr_ptr`.
    - If not stalled, pop the granted engine (one-hot), check its literal, and set `rr_ptr` = grant+1 mod NUM_ENGINE.
    - `rr_ptr` advances on DUP and invalid drops too.
    - `mem2sch_ready`=0.
    - Go to DONE when, in one cycle, all of these hold: no `eng2sch_valid`, no `eng2sch_busy`, `sch2eng_valid`=0, and `stall`=0.
  - **CONFLICT**: `conflict`=1; no pops, no broadcasts, `mem2sch_ready`=0; held until `rst`.
  - **DONE**: `done`=1; otherwise the same as CONFLICT; held until `rst`.
- Priority: a CONTRA always wins, so `conflict` takes precedence over `done`.

## Timing
- Reset values:
  - All outputs are 0.
  - `rr_ptr`=0, state=LOAD, table cleared.
  - `rst` asserted mid-run aborts everything on the next edge, including an in-flight broadcast.
- Check-to-broadcast latency is 1 cycle. At most 1 literal is accepted per cycle, which gives a throughput of 1 literal/cycle.
- A table write at edge t is visible to the lookup in cycle t+1. There is no same-cycle hazard because only one literal is accepted per cycle.
- `sch2eng_valid` is a single-cycle pulse per broadcast. Engines must absorb it, which they can because the broadcast is only issued when `stall`=0 at acceptance.
- `conflict` rises 1 cycle after the CONTRA acceptance cycle.
- `done` rises 1 cycle after the idle-condition cycle.
- `sch2eng_pop` is asserted only in a RUN cycle with `stall`=0 and `eng2sch_valid[g]`=1, and is never asserted for more than one engine.

## Test plan
- **Memory load:** after reset, send 10, 20, 30, 40, 50 then assert done.
  - Broadcasts 10..50 appear one cycle after each acceptance.
  - State is RUN after the done cycle.
  - No pops occur during LOAD.
- **Duplicate drop:** memory sends 5; then engine 2 head is 5 and engine 3 head is -7.
  - Engine 2 is popped with no broadcast.
  - Engine 3 is popped and -7 is broadcast.
  - `rr_ptr` wraps correctly.
- **Conflict:** memory sends -3; engine 0 head is 3.
  - Pop occurs and `conflict`=1 the next cycle.
  - No further pops or broadcasts.
  - `done` stays 0 even when all engines go idle.
- **Round-robin fairness with stall:** all 4 engines hold distinct new literals; `eng2sch_full[1]` is pulsed for 2 cycles.
  - Grant order is 0,1,2,3.
  - Zero pops and zero broadcasts during the stall.
  - Order resumes unchanged after the stall.
- **Completion:** after the memory phase, engines raise valid then busy, then all drop.
  - `done`=1 exactly 1 cycle after the first all-idle, non-stalled cycle with `sch2eng_valid`=0.
- **Invalid literal and reset mid-run:**
  - An engine head of 0 or LIT_IDX_MAX+1 is popped and dropped.
  - Asserting `rst` during RUN clears the table, so literal 10 is rebroadcast as NEW after reload.
